dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the data-memory interface that the pipeline MEM stage drives.
- Accepts one load/store request at a time on a valid/ready handshake.
- Inserts a programmable number of wait states, performs a byte-lane-masked word access, and returns the result on a valid/ready response channel.
- Replaces the single-cycle data memory when MEM-stage stall support is added.

Parameters:
- DEPTH_LOG2, 6, log2 of the number of 32-bit words (64 words).
- WAIT_CYCLES, 2, extra cycles between request acceptance and the storage access; legal range 0..15.
- DATA_W, 32, data word width; fixed at 32, byte lanes = DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i covers bits [8i+7:8i]; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester takes the response.
- resp_rdata  out  32  load data; 0 for store responses.
- resp_err  out  1  error flag (see Optional Feature).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset is asserted while reset=0, asynchronously. On reset:
  - FSM = IDLE, wait counter = 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - All storage words cleared to 0.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: req_ready=1. When req_valid&req_ready, latch write/addr/wdata/be. Go to WAIT if WAIT_CYCLES>0, otherwise to ACCESS.
  - WAIT: counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Go to ACCESS when counter==0.
  - ACCESS: exactly one cycle.
    - Word index = latched addr[DEPTH_LOG2+1:2].
    - Store: commit only lanes with be=1; rdata register <= 0.
    - Load: rdata register <= stored word.
    - Next state RESP.
  - RESP: resp_valid=1, with resp_rdata and resp_err held stable. Go to IDLE on resp_ready=1; otherwise stay, and outputs must not change.
- req_ready=0 in WAIT, ACCESS and RESP. A request is never accepted in the same cycle a response completes, so the minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- Latency: resp_valid rises WAIT_CYCLES+2 rising edges after the accepting edge (WAIT_CYCLES=0 gives 2).
- Store with be=4'b0000: completes normally, memory unchanged.
- Loads return pre-access contents. There is no read-after-write hazard, because requests are strictly serialised.
- A store is committed only at the ACCESS edge. Reset before that edge discards it; reset after it keeps nothing, since storage is cleared.
- Inputs other than req_valid are don't-care while req_ready=0.
- resp_rdata returns to 0 when leaving RESP.

Optional Feature:
- Macro: DMEM_RESP_ERR_EN.
- Defined: a request with addr[1:0]!=0, or with any of addr[31:DEPTH_LOG2+2] nonzero, is an error.
  - Timing is unchanged.
  - ACCESS performs no storage read or write.
  - The response carries resp_err=1 and resp_rdata=0.
- Undefined:
  - addr[1:0] and the upper address bits are ignored, so addresses wrap modulo the memory size.
  - resp_err is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - the state enumeration (IDLE, WAIT, ACCESS, RESP);
  - BYTE_LANES=4 and WORD_OFFSET_BITS=2;
  - the default DEPTH_LOG2 and WAIT_CYCLES values.
- One sub-module, dmem_array: 2^DEPTH_LOG2 x 32 storage.
  - One synchronous port with a write enable and a 4-bit lane mask.
  - Combinational read of the addressed word.
  - Asynchronous active-low clear.
- The FSM, counter and latches live in dmem_responder.

Test Plan:
- Reset, then a load at address 0x0000_0008: resp_valid after 4 edges (WAIT_CYCLES=2), resp_rdata=0x0000_0000, busy high from accept until the response handshake.
- Store 0xDEADBEEF to 0x0000_0010 with be=4'hF, then store 0x0000_1200 with be=4'b0010, then load 0x10: resp_rdata=0xDEAD12EF.
- Hold resp_ready=0 for 5 cycles after resp_valid: resp_valid and resp_rdata stay stable and req_ready stays 0. Raise resp_ready: next cycle IDLE, req_ready=1.
- Drop reset to 0 while in WAIT for a store of 0x12345678 to 0x4: outputs return to reset values immediately. After release, a load of 0x4 returns 0.
- WAIT_CYCLES=0 build: three back-to-back loads with resp_ready tied 1 complete at a 3-cycle spacing with latency 2.
- With DMEM_RESP_ERR_EN, load 0x0000_0102: resp_err=1, resp_rdata=0. Load 0x0000_0100 (out of range for 64 words): resp_err=1. Neither access modifies storage.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, lane geometry and default sizing.
package dmem_pkg;

  localparam int BYTE_LANES       = 4;
  localparam int WORD_OFFSET_BITS = 2;
  localparam int DEF_DEPTH_LOG2   = 6;
  localparam int DEF_WAIT_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0]           old_word,
                                             input logic [31:0]           new_word,
                                             input logic [BYTE_LANES-1:0] be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage: one synchronous lane-masked write port, combinational read.
// Every word is cleared asynchronously while i_rst_n is low.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int DATA_W     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [BYTE_LANES-1:0] i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= lane_merge(r_mem[i_addr], i_wdata, i_be);
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Serialised load/store responder with programmable wait states in front of dmem_array.
// Address error reporting is built only when DMEM_RESP_ERR_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request; latches it on accept
// WAIT   | counting down the programmed wait states
// ACCESS | single cycle: storage read or lane-masked write
// RESP   | response held until the requester takes it
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int DATA_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e                r_state;
  state_e                w_next;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic                  r_bad;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [BYTE_LANES-1:0] r_be;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [DATA_W-1:0]     w_mem_rdata;
  logic                  w_accept;
  logic                  w_req_bad;
  logic                  w_mem_we;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

`ifdef DMEM_RESP_ERR_EN
  assign w_req_bad = (bus.req_addr[WORD_OFFSET_BITS-1:0] != '0) ||
                     (bus.req_addr[31:DEPTH_LOG2+WORD_OFFSET_BITS] != '0);
`else
  // Offset and upper bits are ignored so accesses wrap modulo the array size.
  logic w_unused_addr;
  assign w_unused_addr = ^{bus.req_addr[31:DEPTH_LOG2+WORD_OFFSET_BITS],
                           bus.req_addr[WORD_OFFSET_BITS-1:0]};
  assign w_req_bad     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (r_cnt == 4'd0) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   if (bus.resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    busy           = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        busy          = 1'b0;
      end
      ST_RESP: bus.resp_valid = 1'b1;
      default: ;
    endcase
    bus.resp_rdata = r_rdata;
    bus.resp_err   = r_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_bad   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_idx   <= bus.req_addr[DEPTH_LOG2+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
        r_wdata <= bus.req_wdata;
        r_be    <= bus.req_be;
        r_bad   <= w_req_bad;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // Response data is captured once in ACCESS and held untouched through RESP.
      if (r_state == ST_ACCESS) begin
        r_rdata <= (r_write || r_bad) ? '0 : w_mem_rdata;
        r_err   <= r_bad;
      end else if ((r_state == ST_RESP) && bus.resp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  assign w_mem_we = (r_state == ST_ACCESS) && r_write && !r_bad;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_array (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_mem_we),
    .i_be    (r_be),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
// Expected responses come from a reference word model queued per accepted request.
module tb_dmem_responder;

  logic clk;
  logic rst_n;
  logic busy0;
  logic busy1;
  int   checks;
  int   errors;
  int   cyc;

  logic [31:0] mdl [64];
  logic [31:0] sb_rd [$];
  logic        sb_err [$];

  int          acc_q [$];
  int          done_q [$];
  logic [31:0] rd_q [$];

  dmem_responder_if m0();
  dmem_responder_if m1();

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2), .DATA_W(32)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (m0),
    .busy  (busy0)
  );

  dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0), .DATA_W(32)) u_dut0 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (m1),
    .busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (m1.req_valid && m1.req_ready) acc_q.push_back(cyc);
    if (m1.resp_valid && m1.resp_ready) begin
      done_q.push_back(cyc);
      rd_q.push_back(m1.resp_rdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
  endtask

  // One complete transaction on the WAIT_CYCLES=2 instance, holding the response for 'hold' cycles.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input string tag);
    logic        bad;
    logic [31:0] e_rd;
    logic        e_err;
    int          n;
    int          lat;
    bad = 1'b0;
`ifdef DMEM_RESP_ERR_EN
    bad = (addr[1:0] != 2'b00) || (addr[31:8] != 24'h0);
`endif
    sb_rd.push_back((wr || bad) ? 32'h0 : mdl[addr[7:2]]);
    sb_err.push_back(bad);
    if (wr && !bad) begin
      for (int b = 0; b < 4; b++) if (be[b]) mdl[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
    end

    @(negedge clk);
    m0.req_valid = 1'b1;
    m0.req_write = wr;
    m0.req_addr  = addr;
    m0.req_wdata = wdata;
    m0.req_be    = be;
    n = 0;
    while (!m0.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_ready"}, {31'h0, m0.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    m0.req_valid = 1'b0;
    chk({tag, "_busy_accept"}, {31'h0, busy0}, 32'h1);

    lat = 1;
    while (!m0.resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_resp_valid"}, {31'h0, m0.resp_valid}, 32'h1);
    chk({tag, "_latency"}, 32'(lat), 32'd4);

    e_rd  = sb_rd.pop_front();
    e_err = sb_err.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {31'h0, m0.resp_valid}, 32'h1);
      chk({tag, "_hold_rdata"}, m0.resp_rdata, e_rd);
      chk({tag, "_hold_ready"}, {31'h0, m0.req_ready}, 32'h0);
    end
    chk({tag, "_rdata"}, m0.resp_rdata, e_rd);
    chk({tag, "_err"}, {31'h0, m0.resp_err}, {31'h0, e_err});
    chk({tag, "_busy_resp"}, {31'h0, busy0}, 32'h1);

    @(negedge clk);
    m0.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    m0.resp_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'h0, m0.req_ready}, 32'h1);
    chk({tag, "_idle_valid"}, {31'h0, m0.resp_valid}, 32'h0);
    chk({tag, "_idle_busy"}, {31'h0, busy0}, 32'h0);
    chk({tag, "_idle_rdata"}, m0.resp_rdata, 32'h0);
  endtask

  logic        b2b_wr [3];
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_wd [3];
  logic [31:0] b2b_exp [3];

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    m0.req_valid = 1'b0; m0.req_write = 1'b0; m0.req_addr = 32'h0;
    m0.req_wdata = 32'h0; m0.req_be = 4'h0; m0.resp_ready = 1'b0;
    m1.req_valid = 1'b0; m1.req_write = 1'b0; m1.req_addr = 32'h0;
    m1.req_wdata = 32'h0; m1.req_be = 4'h0; m1.resp_ready = 1'b0;
    clear_model();

    #3;
    chk("rst_req_ready", {31'h0, m0.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, m0.resp_valid}, 32'h0);
    chk("rst_rdata", m0.resp_rdata, 32'h0);
    chk("rst_err", {31'h0, m0.resp_err}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_busy_w0", {31'h0, busy1}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, "ld8");
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, "st10_full");
    do_txn(1'b1, 32'h0000_0010, 32'h0000_1200, 4'b0010, 0, "st10_lane1");
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 5, "ld10_hold");
    do_txn(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 0, "st10_be0");
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, "ld10_after_be0");
    do_txn(1'b1, 32'h0000_0100, 32'h0000_55AA, 4'hF, 0, "st100");
    do_txn(1'b0, 32'h0000_0102, 32'h0, 4'h0, 0, "ld102");
    do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, "ld100");
    do_txn(1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, "ld0");

    // Reset while a store is still counting wait states.
    @(negedge clk);
    m0.req_valid = 1'b1; m0.req_write = 1'b1; m0.req_addr = 32'h0000_0004;
    m0.req_wdata = 32'h1234_5678; m0.req_be = 4'hF;
    @(posedge clk);
    #1;
    m0.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wait_busy", {31'h0, busy0}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'h0, m0.req_ready}, 32'h1);
    chk("mid_rst_valid", {31'h0, m0.resp_valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy0}, 32'h0);
    chk("mid_rst_rdata", m0.resp_rdata, 32'h0);
    chk("mid_rst_err", {31'h0, m0.resp_err}, 32'h0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, "ld4_after_rst");
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, "ld10_after_rst");

    // Back-to-back traffic on the zero-wait instance, response always taken.
    b2b_wr[0] = 1'b1; b2b_addr[0] = 32'h0000_0020; b2b_wd[0] = 32'hCAFE_F00D; b2b_exp[0] = 32'h0;
    b2b_wr[1] = 1'b0; b2b_addr[1] = 32'h0000_0020; b2b_wd[1] = 32'h0;         b2b_exp[1] = 32'hCAFE_F00D;
    b2b_wr[2] = 1'b0; b2b_addr[2] = 32'h0000_0024; b2b_wd[2] = 32'h0;         b2b_exp[2] = 32'h0;
    m1.resp_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      int n;
      m1.req_valid = 1'b1;
      m1.req_write = b2b_wr[i];
      m1.req_addr  = b2b_addr[i];
      m1.req_wdata = b2b_wd[i];
      m1.req_be    = 4'hF;
      n = 0;
      while (!m1.req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    m1.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_accepts", 32'(acc_q.size()), 32'd3);
    chk("b2b_responses", 32'(done_q.size()), 32'd3);
    if (acc_q.size() == 3 && done_q.size() == 3 && rd_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b_latency_%0d", i), 32'(done_q[i] - acc_q[i]), 32'd2);
        chk($sformatf("b2b_rdata_%0d", i), rd_q[i], b2b_exp[i]);
        if (i > 0) chk($sformatf("b2b_spacing_%0d", i), 32'(acc_q[i] - acc_q[i-1]), 32'd3);
      end
    end
    m1.resp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
